ahb_addr_decoder_ds: RTL and testbench
======================================

Name: ahb_addr_decoder_ds

Overview:
Parametrised AHB-Lite address decoder for one master layer of the multilayer interconnect. It generalises the plain range decoder in four ways:
- Priority resolution of overlapping regions.
- A registered data-phase select for the response mux.
- A built-in default slave that gives the two-cycle ERROR response on unmapped transfers.
- A sticky error-capture register with a saturating counter.

Parameters:
NUM_SLAVES, 2, number of mapped slave regions (1..16)
ADDR_WIDTH, 32, address width in bits
START_ADDR, all-zero array [0:NUM_SLAVES-1], inclusive region start per slave
END_ADDR, all-zero array [0:NUM_SLAVES-1], inclusive region end per slave
ERR_CNT_W, 8, width of the saturating decode-error counter

Ports:
i_clk  in  1  bus clock
i_rstn  in  1  reset; asynchronous assert, active-low
i_haddr  in  ADDR_WIDTH  master address-phase address
i_htrans  in  2  master HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
i_hready  in  1  layer HREADY (output of the response mux)
i_err_clr  in  1  synchronous clear of the error-capture registers
o_hsel  out  NUM_SLAVES  one-hot address-phase select, combinational
o_def_sel  out  1  address-phase select of the default slave, combinational
o_hsel_dp  out  NUM_SLAVES  registered one-hot data-phase select for the response mux
o_def_sel_dp  out  1  registered data-phase select of the default slave
o_def_hreadyout  out  1  default-slave HREADYOUT
o_def_hresp  out  1  default-slave HRESP (1 = ERROR)
o_err_cnt  out  ERR_CNT_W  count of unmapped NONSEQ/SEQ transfers, saturating
o_err_addr  out  ADDR_WIDTH  address of the most recent unmapped transfer

Behaviour:
- Hit: hit[i] = (i_haddr >= START_ADDR[i]) && (i_haddr <= END_ADDR[i]), unsigned compare. A region with START > END never hits.
- Overlap: the lowest hitting index wins, so o_hsel is strictly one-hot or zero.
- o_def_sel = 1 when no region hits. It depends only on i_haddr, not on i_htrans.
- Data-phase register: when i_hready=1, o_hsel_dp <= o_hsel and o_def_sel_dp <= o_def_sel. When i_hready=0, both hold.
- Reset values: o_hsel_dp = 0; o_def_sel_dp = 1 (so the default slave drives the bus ready); o_def_hreadyout = 1; o_def_hresp = 0; o_err_cnt = 0; o_err_addr = 0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: hreadyout=1, hresp=0. Go to ERR1 when i_hready & i_htrans[1] & o_def_sel.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2 the next cycle.
  - ERR2: hreadyout=1, hresp=1. If i_hready & i_htrans[1] & o_def_sel, go to ERR1 (back-to-back error). Otherwise go to IDLE.
- IDLE/BUSY transfers to unmapped space: zero-wait OKAY, FSM stays in IDLE, no error is counted.
- The FSM outputs are registered state decodes, so there is no combinational path from inputs to o_def_hreadyout/o_def_hresp.
- Error capture: on each transition into ERR1, o_err_addr <= i_haddr and o_err_cnt increments. The counter saturates at 2^ERR_CNT_W-1 and does not wrap.
- i_err_clr: o_err_cnt <= 0 and o_err_addr <= 0. If a new error occurs in the same cycle, the new error wins: o_err_cnt <= 1 and o_err_addr <= i_haddr.
- Reset mid-operation: asserting i_rstn low in ERR1 or ERR2 forces IDLE and the reset values immediately, with no clock needed.
- Latency: o_hsel/o_def_sel are 0 cycles after i_haddr. The data-phase selects and the FSM response start 1 cycle after the accepting i_hready edge.

Test Plan:
Parameters for all scenarios: NUM_SLAVES=3. S0 0x0000_0000..0x0000_0FFF; S1 0x1000_0000..0x1000_FFFF; S2 0x1000_8000..0x1000_8FFF.

- NONSEQ to 0x0000_0FFC, i_hready=1 -> o_hsel=3'b001 at once; o_hsel_dp=3'b001 next cycle; no error counted.
- Overlap: NONSEQ to 0x1000_8004 -> o_hsel=3'b010 (S1 wins over S2); o_def_sel=0.
- Unmapped: NONSEQ to 0x2000_0000 -> next cycle hreadyout=0/hresp=1; cycle after that hreadyout=1/hresp=1; then IDLE; o_err_cnt=1; o_err_addr=0x2000_0000.
- Back-to-back: NONSEQ 0x2000_0000, then NONSEQ 0x3000_0000 presented and accepted in ERR2 -> sequence ERR1, ERR2, ERR1, ERR2; o_err_cnt=2; o_err_addr=0x3000_0000.
- IDLE htrans to 0x2000_0000 -> o_def_sel=1 and o_def_sel_dp=1 next cycle; hreadyout=1, hresp=0; o_err_cnt unchanged.
- Saturation and clear, with ERR_CNT_W=2:
  - Four errors -> o_err_cnt=3.
  - i_err_clr together with a new error -> o_err_cnt=1.
  - i_rstn low during ERR1 -> hreadyout=1, hresp=0, o_def_sel_dp=1 with no clock edge.

Source files
------------

// File: rtl/ahb_addr_decoder_ds.sv
// ---------------------------------------------------------------------------
// ahb_addr_decoder_ds
//
// AHB-Lite address decoder for one master layer of the multilayer
// interconnect.
//
// Decode: each slave owns an inclusive address region. Regions may overlap,
// and the lowest index wins. Addresses that match no region select the
// built-in default slave.
//
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle
// ERROR response. Every unmapped transfer it accepts is recorded in a sticky
// capture register (last address seen plus a saturating counter).
//
// Ports
//   i_clk            bus clock
//   i_rstn           asynchronous active-low reset
//   i_haddr          address-phase address
//   i_htrans         HTRANS (only bit 1, "active transfer", is used)
//   i_hready         layer HREADY, i.e. the output of the response mux
//   i_err_clr        synchronous clear of the error-capture registers
//   o_hsel           one-hot address-phase slave select (combinational)
//   o_def_sel        address-phase default-slave select (combinational)
//   o_hsel_dp        registered data-phase slave select for the response mux
//   o_def_sel_dp     registered data-phase default-slave select
//   o_def_hreadyout  default-slave HREADYOUT
//   o_def_hresp      default-slave HRESP (1 = ERROR)
//   o_err_cnt        saturating count of unmapped active transfers
//   o_err_addr       address of the most recent unmapped active transfer
// ---------------------------------------------------------------------------
module ahb_addr_decoder_ds #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR [0:NUM_SLAVES-1] = '{default: '0},
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   [0:NUM_SLAVES-1] = '{default: '0},
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [ADDR_WIDTH-1:0] i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hready,
  input  logic                  i_err_clr,
  output logic [NUM_SLAVES-1:0] o_hsel,
  output logic                  o_def_sel,
  output logic [NUM_SLAVES-1:0] o_hsel_dp,
  output logic                  o_def_sel_dp,
  output logic                  o_def_hreadyout,
  output logic                  o_def_hresp,
  output logic [ERR_CNT_W-1:0]  o_err_cnt,
  output logic [ADDR_WIDTH-1:0] o_err_addr
);

  // -------------------------------------------------------------------------
  // Region hit detection
  // -------------------------------------------------------------------------
  logic [NUM_SLAVES-1:0] hit;
  // lower_hit[i] is set when any region with an index below i hits.
  logic [NUM_SLAVES-1:0] lower_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_region
      // Compare through the borrow of an (ADDR_WIDTH+1)-bit subtraction.
      // This stays a true unsigned compare even when a bound is zero or
      // all-ones, where a plain relational operator folds to a constant.
      logic                  lo_borrow;
      logic                  hi_borrow;
      logic [ADDR_WIDTH-1:0] unused_lo_diff;
      logic [ADDR_WIDTH-1:0] unused_hi_diff;

      assign {lo_borrow, unused_lo_diff} = {1'b0, i_haddr} - {1'b0, START_ADDR[gi]};
      assign {hi_borrow, unused_hi_diff} = {1'b0, END_ADDR[gi]} - {1'b0, i_haddr};

      // A region whose start lies above its end can never satisfy both
      // bounds, so it never hits.
      assign hit[gi] = ~lo_borrow & ~hi_borrow;

      if (gi == 0) begin : g_first
        assign lower_hit[gi] = 1'b0;
      end else begin : g_rest
        assign lower_hit[gi] = lower_hit[gi-1] | hit[gi-1];
      end

      // Lowest hitting index wins, which keeps o_hsel one-hot or zero.
      assign o_hsel[gi] = hit[gi] & ~lower_hit[gi];
    end
  endgenerate

  // The default slave is selected purely on address, not on HTRANS.
  assign o_def_sel = ~|hit;

  // HTRANS[0] only distinguishes IDLE/BUSY and NONSEQ/SEQ within each pair.
  // The decoder only needs to know whether a transfer is active.
  logic unused_htrans0;
  assign unused_htrans0 = i_htrans[0];

  // -------------------------------------------------------------------------
  // Data-phase select register
  // -------------------------------------------------------------------------
  logic [NUM_SLAVES-1:0] hsel_dp_q, hsel_dp_d;
  logic                  def_sel_dp_q, def_sel_dp_d;

  always_comb begin
    hsel_dp_d    = hsel_dp_q;
    def_sel_dp_d = def_sel_dp_q;
    if (i_hready) begin
      hsel_dp_d    = o_hsel;
      def_sel_dp_d = o_def_sel;
    end
  end

  // Out of reset the default slave owns the data phase. That way the
  // response mux sees a ready, OKAY bus before any transfer is accepted.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hsel_dp_q    <= '0;
      def_sel_dp_q <= 1'b1;
    end else begin
      hsel_dp_q    <= hsel_dp_d;
      def_sel_dp_q <= def_sel_dp_d;
    end
  end

  assign o_hsel_dp    = hsel_dp_q;
  assign o_def_sel_dp = def_sel_dp_q;

  // -------------------------------------------------------------------------
  // Default-slave response FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_state_e;

  def_state_e state_q, state_d;

  // An active transfer to unmapped space is accepted in this cycle.
  logic err_accept;
  assign err_accept = i_hready & i_htrans[1] & o_def_sel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (err_accept) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        // A new unmapped transfer accepted in the last error cycle starts
        // the next error response back to back.
        state_d = err_accept ? ST_ERR1 : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode the state register directly, so there is no
  // combinational path from the inputs to the response.
  assign o_def_hreadyout = (state_q != ST_ERR1);
  assign o_def_hresp     = (state_q != ST_IDLE);

  // -------------------------------------------------------------------------
  // Sticky error capture
  // -------------------------------------------------------------------------
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_enter;

  // ERR1 is only ever entered from IDLE or ERR2, so a next state of ERR1
  // always marks a fresh transition into it.
  assign err_enter = (state_d == ST_ERR1);

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (err_enter) begin
      // A clear in the same cycle as a new error still keeps that error.
      if (i_err_clr) begin
        err_cnt_d = ERR_CNT_W'(1);
      end else if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      err_addr_d = i_haddr;
    end else if (i_err_clr) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign o_err_cnt  = err_cnt_q;
  assign o_err_addr = err_addr_q;

endmodule

// File: tb/tb_ahb_addr_decoder_ds.sv
// ---------------------------------------------------------------------------
// tb_ahb_addr_decoder_ds
//
// Scoreboard bench for ahb_addr_decoder_ds with three slave regions.
// Two instances share one stimulus stream: the main one uses an 8-bit error
// counter, and the second uses a 2-bit counter to exercise saturation.
// Each transaction pushes the registered results expected one clock later.
// Those results are popped and compared after the edge.
// ---------------------------------------------------------------------------
module tb_ahb_addr_decoder_ds;

  localparam int NS = 3;
  localparam int AW = 32;
  localparam logic [AW-1:0] S_START [0:NS-1] = '{32'h0000_0000, 32'h1000_0000, 32'h1000_8000};
  localparam logic [AW-1:0] S_END   [0:NS-1] = '{32'h0000_0FFF, 32'h1000_FFFF, 32'h1000_8FFF};

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          i_clk;
  logic          i_rstn;
  logic [AW-1:0] i_haddr;
  logic [1:0]    i_htrans;
  logic          i_hready;
  logic          i_err_clr;

  logic [NS-1:0] o_hsel, o_hsel_dp;
  logic          o_def_sel, o_def_sel_dp, o_def_hreadyout, o_def_hresp;
  logic [7:0]    o_err_cnt;
  logic [AW-1:0] o_err_addr;

  logic [NS-1:0] s_hsel, s_hsel_dp;
  logic          s_def_sel, s_def_sel_dp, s_def_hreadyout, s_def_hresp;
  logic [1:0]    s_err_cnt;
  logic [AW-1:0] s_err_addr;

  ahb_addr_decoder_ds #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .START_ADDR(S_START), .END_ADDR(S_END), .ERR_CNT_W(8)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_haddr(i_haddr), .i_htrans(i_htrans),
    .i_hready(i_hready), .i_err_clr(i_err_clr),
    .o_hsel(o_hsel), .o_def_sel(o_def_sel), .o_hsel_dp(o_hsel_dp),
    .o_def_sel_dp(o_def_sel_dp), .o_def_hreadyout(o_def_hreadyout),
    .o_def_hresp(o_def_hresp), .o_err_cnt(o_err_cnt), .o_err_addr(o_err_addr)
  );

  ahb_addr_decoder_ds #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .START_ADDR(S_START), .END_ADDR(S_END), .ERR_CNT_W(2)
  ) dut_sat (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_haddr(i_haddr), .i_htrans(i_htrans),
    .i_hready(i_hready), .i_err_clr(i_err_clr),
    .o_hsel(s_hsel), .o_def_sel(s_def_sel), .o_hsel_dp(s_hsel_dp),
    .o_def_sel_dp(s_def_sel_dp), .o_def_hreadyout(s_def_hreadyout),
    .o_def_hresp(s_def_hresp), .o_err_cnt(s_err_cnt), .o_err_addr(s_err_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Registered results expected after one clock.
  typedef struct {
    logic [NS-1:0] hsel_dp;
    logic          def_dp;
    logic          rdy;
    logic          resp;
    logic [7:0]    cnt;
    logic [1:0]    cnt_s;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: 0 = IDLE, 1 = ERR1, 2 = ERR2.
  int            m_state;
  logic [NS-1:0] m_hsel_dp;
  logic          m_def_dp;
  logic [7:0]    m_cnt;
  logic [1:0]    m_cnt_s;
  logic [AW-1:0] m_addr;

  task automatic model_reset();
    m_state   = 0;
    m_hsel_dp = '0;
    m_def_dp  = 1'b1;
    m_cnt     = '0;
    m_cnt_s   = '0;
    m_addr    = '0;
  endtask

  function automatic logic [NS-1:0] decode(input logic [AW-1:0] a);
    logic [NS-1:0] r;
    r = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (a >= S_START[i] && a <= S_END[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // One bus cycle. Outside ERR1, HREADY follows the default slave; in ERR1
  // it is low. The hold argument forces it low to model a stalling slave.
  task automatic step(input logic [AW-1:0] addr, input logic [1:0] trans,
                      input logic clr, input logic hold);
    logic          hr, ed, start;
    logic [NS-1:0] eh;
    int            ns;
    exp_t          e, got;

    hr = hold ? 1'b0 : (m_state != 1);
    i_haddr   = addr;
    i_htrans  = trans;
    i_hready  = hr;
    i_err_clr = clr;
    #1;
    eh = decode(addr);
    ed = (eh == '0);
    check_eq("hsel", 64'(o_hsel), 64'(eh));
    check_eq("def_sel", 64'(o_def_sel), 64'(ed));

    start = hr & trans[1] & ed;
    if (m_state == 1)      ns = 2;
    else if (start)        ns = 1;
    else                   ns = 0;
    if (ns == 1) begin
      m_cnt   = clr ? 8'd1 : ((m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1);
      m_cnt_s = clr ? 2'd1 : ((m_cnt_s == 2'd3) ? m_cnt_s : m_cnt_s + 2'd1);
      m_addr  = addr;
    end else if (clr) begin
      m_cnt   = '0;
      m_cnt_s = '0;
      m_addr  = '0;
    end
    if (hr) begin
      m_hsel_dp = eh;
      m_def_dp  = ed;
    end
    m_state   = ns;
    e.hsel_dp = m_hsel_dp;
    e.def_dp  = m_def_dp;
    e.rdy     = (ns != 1);
    e.resp    = (ns != 0);
    e.cnt     = m_cnt;
    e.cnt_s   = m_cnt_s;
    e.addr    = m_addr;
    exp_q.push_back(e);

    @(posedge i_clk);
    #1;
    txn++;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      got = exp_q.pop_front();
      check_eq("hsel_dp", 64'(o_hsel_dp), 64'(got.hsel_dp));
      check_eq("def_sel_dp", 64'(o_def_sel_dp), 64'(got.def_dp));
      check_eq("hreadyout", 64'(o_def_hreadyout), 64'(got.rdy));
      check_eq("hresp", 64'(o_def_hresp), 64'(got.resp));
      check_eq("err_cnt", 64'(o_err_cnt), 64'(got.cnt));
      check_eq("err_addr", 64'(o_err_addr), 64'(got.addr));
      check_eq("err_cnt_sat", 64'(s_err_cnt), 64'(got.cnt_s));
      check_eq("sat_hresp", 64'(s_def_hresp), 64'(got.resp));
    end
    $display("txn %0d addr=%h trans=%b hready=%b clr=%b -> hsel_dp=%b def_dp=%b rdy=%b resp=%b cnt=%0d cnt_sat=%0d err_addr=%h",
             txn, addr, trans, hr, clr, o_hsel_dp, o_def_sel_dp, o_def_hreadyout,
             o_def_hresp, o_err_cnt, s_err_cnt, o_err_addr);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_hsel_dp"}, 64'(o_hsel_dp), 64'd0);
    check_eq({tag, "_def_sel_dp"}, 64'(o_def_sel_dp), 64'd1);
    check_eq({tag, "_hreadyout"}, 64'(o_def_hreadyout), 64'd1);
    check_eq({tag, "_hresp"}, 64'(o_def_hresp), 64'd0);
    check_eq({tag, "_err_cnt"}, 64'(o_err_cnt), 64'd0);
    check_eq({tag, "_err_addr"}, 64'(o_err_addr), 64'd0);
    check_eq({tag, "_err_cnt_sat"}, 64'(s_err_cnt), 64'd0);
  endtask

  logic [AW-1:0] pick_addr [0:11];

  initial begin
    pick_addr = '{32'h0000_0000, 32'h0000_0FFF, 32'h0000_1000, 32'h0FFF_FFFF,
                  32'h1000_0000, 32'h1000_7FFF, 32'h1000_8000, 32'h1000_8FFF,
                  32'h1000_FFFF, 32'h1001_0000, 32'h2000_0000, 32'hFFFF_FFFF};

    i_rstn    = 1'b0;
    i_haddr   = '0;
    i_htrans  = T_IDLE;
    i_hready  = 1'b1;
    i_err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_values("reset");
    i_rstn = 1'b1;

    // Mapped accesses, the overlap, and region boundaries.
    step(32'h0000_0FFC, T_NONSEQ, 1'b0, 1'b0);
    check_eq("s0_hsel_dp", 64'(o_hsel_dp), 64'b001);
    check_eq("s0_no_err", 64'(o_err_cnt), 64'd0);
    step(32'h1000_8004, T_NONSEQ, 1'b0, 1'b0);
    check_eq("overlap_hsel_dp", 64'(o_hsel_dp), 64'b010);
    step(32'h1000_0000, T_SEQ,    1'b0, 1'b0);
    step(32'h1000_FFFF, T_SEQ,    1'b0, 1'b0);
    step(32'h0000_1000, T_BUSY,   1'b0, 1'b0);
    step(32'h1001_0000, T_IDLE,   1'b0, 1'b0);

    // Single unmapped transfer: ERR1, ERR2, then back to IDLE.
    step(32'h2000_0000, T_NONSEQ, 1'b0, 1'b0);
    check_eq("err1_rdy", 64'(o_def_hreadyout), 64'd0);
    check_eq("err1_resp", 64'(o_def_hresp), 64'd1);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);
    check_eq("err2_rdy", 64'(o_def_hreadyout), 64'd1);
    check_eq("err2_resp", 64'(o_def_hresp), 64'd1);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);
    check_eq("unmapped_cnt", 64'(o_err_cnt), 64'd1);
    check_eq("unmapped_addr", 64'(o_err_addr), 64'h2000_0000);

    // Back-to-back errors: the second address is held through ERR1 and
    // accepted in ERR2.
    step(32'h2000_0000, T_NONSEQ, 1'b0, 1'b0);
    step(32'h3000_0000, T_NONSEQ, 1'b0, 1'b0);
    step(32'h3000_0000, T_NONSEQ, 1'b0, 1'b0);
    check_eq("b2b_err1_rdy", 64'(o_def_hreadyout), 64'd0);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);
    check_eq("b2b_cnt", 64'(o_err_cnt), 64'd3);
    check_eq("b2b_addr", 64'(o_err_addr), 64'h3000_0000);

    // A fourth error drives the 2-bit counter into saturation.
    step(32'h2000_0008, T_SEQ,    1'b0, 1'b0);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);
    check_eq("sat_cnt", 64'(s_err_cnt), 64'd3);
    check_eq("four_cnt", 64'(o_err_cnt), 64'd4);

    // An IDLE transfer to unmapped space gets a zero-wait OKAY.
    step(32'h2000_0000, T_IDLE,   1'b0, 1'b0);
    check_eq("idle_def_dp", 64'(o_def_sel_dp), 64'd1);
    check_eq("idle_resp", 64'(o_def_hresp), 64'd0);
    check_eq("idle_cnt", 64'(o_err_cnt), 64'd4);

    // With HREADY low, the data-phase select holds.
    step(32'h0000_0010, T_NONSEQ, 1'b0, 1'b1);
    check_eq("hold_def_dp", 64'(o_def_sel_dp), 64'd1);
    step(32'h0000_0010, T_NONSEQ, 1'b0, 1'b0);

    // A clear that coincides with a new error keeps the new error.
    step(32'h2000_0004, T_NONSEQ, 1'b1, 1'b0);
    check_eq("clr_err_cnt", 64'(o_err_cnt), 64'd1);
    check_eq("clr_err_cnt_sat", 64'(s_err_cnt), 64'd1);
    check_eq("clr_err_addr", 64'(o_err_addr), 64'h2000_0004);
    step(32'h0000_0000, T_IDLE,   1'b1, 1'b0);
    check_eq("clr_only_cnt", 64'(o_err_cnt), 64'd0);
    step(32'h0000_0000, T_IDLE,   1'b0, 1'b0);

    // Random mix of interesting addresses and transfer types.
    for (int k = 0; k < 40; k++) begin
      step(pick_addr[$urandom_range(0, 11)], 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end
    step(32'h0000_0000, T_IDLE, 1'b0, 1'b0);
    step(32'h0000_0000, T_IDLE, 1'b0, 1'b0);

    // Asynchronous reset while the FSM is in ERR1.
    step(32'h2000_0000, T_NONSEQ, 1'b0, 1'b0);
    check_eq("pre_rst_rdy", 64'(o_def_hreadyout), 64'd0);
    #1;
    i_rstn = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    step(32'h1000_8FFF, T_NONSEQ, 1'b0, 1'b0);
    check_eq("post_rst_hsel_dp", 64'(o_hsel_dp), 64'b010);

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
